// File: rtl/audio_pkg.sv
// Shared constants and capture-FSM state type for the audio input path.
package audio_pkg;
  localparam int SAMPLE_W             = 32;
  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_DECAY_PERIOD = 50000;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } cap_state_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on head_data whenever empty=0.
module audio_sample_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (level_reg == '0);
  assign full      = (level_reg == (AW+1)'(DEPTH));
  assign level     = level_reg;
  assign head_data = mem[rd_ptr_reg];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      level_reg <= level_reg + 1'b1;
      else if (do_pop && !do_push) level_reg <= level_reg - 1'b1;
    end
  end
endmodule

// File: rtl/audio_in_reader.sv
// Reads L/R pairs from the Audio_Controller ADC side, buffers them with a mono downmix,
// and tracks a decaying peak level plus a sticky overflow flag.
module audio_in_reader #(
  parameter int SAMPLE_W     = audio_pkg::SAMPLE_W,
  parameter int DEPTH        = audio_pkg::DEFAULT_DEPTH,
  parameter int DECAY_PERIOD = audio_pkg::DEFAULT_DECAY_PERIOD
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    audio_in_available,
  input  logic [SAMPLE_W-1:0]     left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]     right_channel_audio_in,
  output logic                    read_audio_in,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [SAMPLE_W-1:0]     sample_left,
  output logic [SAMPLE_W-1:0]     sample_right,
  output logic [SAMPLE_W-1:0]     sample_mono,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic [SAMPLE_W-2:0]     peak_level
);
  import audio_pkg::*;

  localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  cap_state_t                 state_reg;
  logic                       overflow_reg;
  logic [SAMPLE_W-2:0]        peak_reg;
  logic [CW-1:0]              decay_cnt_reg;

  logic signed [SAMPLE_W-1:0] mono;
  logic [SAMPLE_W-1:0]        mag_full;
  logic [SAMPLE_W-2:0]        mag;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       push;
  logic                       drop;
  logic                       decay_wrap;
  logic [3*SAMPLE_W-1:0]      head_data;

  assign read_audio_in = ~reset & (state_reg == IDLE) & audio_in_available;

  // Halving each channel first keeps the sum in range for every input pair.
  assign mono = ($signed(left_channel_audio_in) >>> 1) + ($signed(right_channel_audio_in) >>> 1);
  assign mag_full = mono[SAMPLE_W-1] ? (-mono) : mono;
  assign mag      = mag_full[SAMPLE_W-1] ? '1 : mag_full[SAMPLE_W-2:0];

  assign pop  = sample_valid & sample_ready;
  assign push = read_audio_in & (~fifo_full | pop);
  assign drop = read_audio_in & fifo_full & ~pop;

  assign decay_wrap = (decay_cnt_reg == CW'(DECAY_PERIOD - 1));

  audio_sample_fifo #(
    .WIDTH (3*SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (push),
    .push_data ({left_channel_audio_in, right_channel_audio_in, mono}),
    .pop       (pop),
    .head_data (head_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sample_valid = ~fifo_empty;
  assign {sample_left, sample_right, sample_mono} = head_data;
  assign overflow   = overflow_reg;
  assign peak_level = peak_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (audio_in_available) state_reg <= GAP;
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Peak meter: a louder capture (kept or dropped) overrides the periodic decay step.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      peak_reg      <= '0;
      decay_cnt_reg <= '0;
    end else begin
      decay_cnt_reg <= decay_wrap ? '0 : decay_cnt_reg + 1'b1;
      if (drop) overflow_reg <= 1'b1;
      if (read_audio_in && (mag > peak_reg)) peak_reg <= mag;
      else if (decay_wrap)                   peak_reg <= peak_reg - (peak_reg >> 4);
    end
  end
endmodule

// File: tb/tb_audio_in_reader.sv
// Self-checking bench for audio_in_reader: directed scenarios plus randomized traffic vs a queue model.
module tb_audio_in_reader;
  localparam int SW    = 32;
  localparam int DEPTH = 8;
  localparam int DP    = 64;
  localparam longint MAXMAG = 64'h7FFF_FFFF;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          audio_in_available = 1'b0;
  logic [SW-1:0] left_channel_audio_in = '0;
  logic [SW-1:0] right_channel_audio_in = '0;
  logic          read_audio_in;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic [SW-1:0] sample_left, sample_right, sample_mono;
  logic [$clog2(DEPTH):0] fifo_level;
  logic          overflow;
  logic [SW-2:0] peak_level;

  audio_in_reader #(.SAMPLE_W(SW), .DEPTH(DEPTH), .DECAY_PERIOD(DP)) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .sample_valid           (sample_valid),
    .sample_ready           (sample_ready),
    .sample_left            (sample_left),
    .sample_right           (sample_right),
    .sample_mono            (sample_mono),
    .fifo_level             (fifo_level),
    .overflow               (overflow),
    .peak_level             (peak_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [SW-1:0] m;
  } pair_t;

  pair_t  m_q[$];
  bit     m_gap, m_ovf;
  longint m_peak;
  int     m_cnt;
  bit     exp_read, obs_read;
  int     checks = 0;
  int     failures = 0;

  // One clock cycle: apply inputs, sample the combinational acknowledge, advance the model.
  task automatic tick(input bit avail, input logic [SW-1:0] l, input logic [SW-1:0] r, input bit rdy);
    longint ls, rs, mono, mag;
    bit pop, wrap;
    pair_t p;
    audio_in_available = avail;
    left_channel_audio_in = l;
    right_channel_audio_in = r;
    sample_ready = rdy;
    #3;
    obs_read = read_audio_in;
    exp_read = !reset && avail && !m_gap;
    @(posedge CLOCK_50);
    #1;
    if (reset) begin
      m_q.delete();
      m_gap = 0; m_ovf = 0; m_peak = 0; m_cnt = 0;
    end else begin
      ls = $signed(l);
      rs = $signed(r);
      mono = (ls / 2 - ((ls < 0 && ls % 2 != 0) ? 1 : 0)) + (rs / 2 - ((rs < 0 && rs % 2 != 0) ? 1 : 0));
      mag = (mono < 0) ? -mono : mono;
      if (mag > MAXMAG) mag = MAXMAG;
      pop = (m_q.size() > 0) && rdy;
      wrap = (m_cnt == DP - 1);
      if (exp_read && mag > m_peak) m_peak = mag;
      else if (wrap) m_peak = m_peak - m_peak / 16;
      m_cnt = wrap ? 0 : m_cnt + 1;
      if (pop) void'(m_q.pop_front());
      if (exp_read) begin
        if (m_q.size() < DEPTH) begin
          p.l = l; p.r = r; p.m = mono[SW-1:0];
          m_q.push_back(p);
        end else begin
          m_ovf = 1;
        end
      end
      m_gap = exp_read;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(0, '0, '0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1, 32'h1234, 32'h5678, 1);
    tick(1, 32'h1234, 32'h5678, 1);
    checks++; if (obs_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%0b exp=0", obs_read); end
    reset = 1'b0;
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    checks++; if (peak_level !== '0) begin failures++; $display("FAIL reset_peak got=%h exp=0", peak_level); end
    $display("test_reset done");
  endtask

  task automatic test_cadence();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1, 32'(i), 32'(i + 100), 0);
      checks++;
      if (obs_read !== ((i % 2) == 0)) begin failures++; $display("FAIL cadence_read cyc=%0d got=%0b exp=%0b", i, obs_read, (i % 2) == 0); end
    end
    checks++; if (fifo_level !== 4'd5) begin failures++; $display("FAIL cadence_level got=%0d exp=5", fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL cadence_ovf got=%0b exp=0", overflow); end
    $display("test_cadence done level=%0d", fifo_level);
  endtask

  task automatic test_mono_fwft();
    do_reset();
    tick(1, 32'h0000_1000, 32'h0000_3000, 0);
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL fwft_valid got=%0b exp=1", sample_valid); end
    checks++; if (sample_mono !== 32'h0000_2000) begin failures++; $display("FAIL fwft_mono got=%h exp=00002000", sample_mono); end
    checks++; if (sample_left !== 32'h0000_1000 || sample_right !== 32'h0000_3000) begin failures++; $display("FAIL fwft_lr got=%h/%h exp=00001000/00003000", sample_left, sample_right); end
    tick(0, '0, '0, 1);
    checks++; if (sample_valid !== 1'b0 || fifo_level !== '0) begin failures++; $display("FAIL fwft_pop valid=%0b level=%0d exp 0/0", sample_valid, fifo_level); end
    tick(0, '0, '0, 1);
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL fwft_pop_empty level=%0d exp=0", fifo_level); end
    $display("test_mono_fwft done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) tick(1, 32'(32'hA000 + i), 32'(32'hB000 + i), 0);
    checks++; if (fifo_level !== 4'(DEPTH) || overflow !== 1'b0) begin failures++; $display("FAIL full_level level=%0d ovf=%0b exp %0d/0", fifo_level, overflow, DEPTH); end
    tick(1, 32'hDEAD, 32'hBEEF, 0);
    checks++; if (obs_read !== 1'b1) begin failures++; $display("FAIL drop_read got=%0b exp=1", obs_read); end
    checks++; if (fifo_level !== 4'(DEPTH) || overflow !== 1'b1) begin failures++; $display("FAIL drop_ovf level=%0d ovf=%0b exp %0d/1", fifo_level, overflow, DEPTH); end
    tick(0, '0, '0, 0);
    tick(1, 32'hCAFE, 32'hF00D, 1);
    checks++; if (obs_read !== 1'b1 || fifo_level !== 4'(DEPTH)) begin failures++; $display("FAIL push_pop_full read=%0b level=%0d exp 1/%0d", obs_read, fifo_level, DEPTH); end
    checks++; if (sample_left !== m_q[0].l) begin failures++; $display("FAIL push_pop_head got=%h exp=%h", sample_left, m_q[0].l); end
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, '0, '0, 1);
      checks++;
      if (sample_valid && (sample_left !== m_q[0].l || sample_mono !== m_q[0].m)) begin failures++; $display("FAIL drain_head i=%0d got=%h exp=%h", i, sample_left, m_q[0].l); end
    end
    checks++; if (fifo_level !== '0 || overflow !== 1'b1) begin failures++; $display("FAIL drain_sticky level=%0d ovf=%0b exp 0/1", fifo_level, overflow); end
    $display("test_overflow done ovf=%0b", overflow);
  endtask

  task automatic test_peak_decay();
    do_reset();
    tick(1, 32'h8000_0000, 32'h8000_0000, 0);
    checks++; if (sample_mono !== 32'h8000_0000) begin failures++; $display("FAIL neg_mono got=%h exp=80000000", sample_mono); end
    checks++; if (peak_level !== 31'h7FFF_FFFF) begin failures++; $display("FAIL neg_peak got=%h exp=7fffffff", peak_level); end
    for (int i = 0; i < DP - 2; i++) tick(0, '0, '0, 0);
    checks++; if (peak_level !== 31'h7FFF_FFFF) begin failures++; $display("FAIL pre_decay got=%h exp=7fffffff", peak_level); end
    tick(0, '0, '0, 0);
    checks++; if (peak_level !== 31'h7800_0000) begin failures++; $display("FAIL decay got=%h exp=78000000", peak_level); end
    $display("test_peak_decay done peak=%h", peak_level);
  endtask

  task automatic test_peak_hold_and_wrap_load();
    int guard;
    do_reset();
    tick(1, 32'h0010_0000, 32'h0010_0000, 1);
    tick(0, '0, '0, 1);
    tick(1, 32'h0008_0000, 32'h0008_0000, 1);
    checks++; if (peak_level !== 31'h0010_0000) begin failures++; $display("FAIL peak_hold got=%h exp=00100000", peak_level); end
    guard = 0;
    while (!(m_cnt == DP - 1 && !m_gap) && guard < 2 * DP) begin
      tick(0, '0, '0, 1);
      guard++;
    end
    checks++;
    if (guard >= 2 * DP) begin
      failures++; $display("FAIL wrap_wait timeout got=%0d exp<%0d", guard, 2 * DP);
    end else begin
      tick(1, 32'h0020_0000, 32'h0020_0000, 1);
      checks++; if (peak_level !== 31'h0020_0000) begin failures++; $display("FAIL wrap_load got=%h exp=00200000", peak_level); end
    end
    $display("test_peak_hold_and_wrap_load done peak=%h", peak_level);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 32'h7000_0000, 32'h0100_0000, 0);
    checks++; if (fifo_level !== 4'd3) begin failures++; $display("FAIL mid_fill level=%0d exp=3", fifo_level); end
    reset = 1'b1;
    tick(1, 32'h1111, 32'h2222, 0);
    reset = 1'b0;
    checks++; if (obs_read !== 1'b0) begin failures++; $display("FAIL mid_reset_read got=%0b exp=0", obs_read); end
    checks++; if (fifo_level !== '0 || sample_valid !== 1'b0 || overflow !== 1'b0 || peak_level !== '0) begin
      failures++; $display("FAIL mid_reset_state level=%0d valid=%0b ovf=%0b peak=%h exp all 0", fifo_level, sample_valid, overflow, peak_level);
    end
    tick(1, 32'h3333, 32'h4444, 0);
    checks++; if (obs_read !== 1'b1 || fifo_level !== 4'd1) begin failures++; $display("FAIL mid_resume read=%0b level=%0d exp 1/1", obs_read, fifo_level); end
    $display("test_reset_midstream done");
  endtask

  task automatic test_random();
    logic [SW-1:0] l, r;
    bit avail, rdy;
    int rdy_pct;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rdy_pct = (i < 300) ? 25 : 75;
      avail = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < rdy_pct);
      l = $urandom;
      r = $urandom;
      if ($urandom_range(7) == 0) l = 32'h8000_0000;
      if ($urandom_range(7) == 0) r = ($urandom_range(1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if ($urandom_range(3) == 0) begin l = l >> 12; r = r >> 12; end
      tick(avail, l, r, rdy);
      checks++; if (obs_read !== exp_read) begin failures++; $display("FAIL rnd_read i=%0d got=%0b exp=%0b", i, obs_read, exp_read); end
      checks++; if (fifo_level !== 4'(m_q.size())) begin failures++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, fifo_level, m_q.size()); end
      checks++; if (sample_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, sample_valid, m_q.size() != 0); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf i=%0d got=%0b exp=%0b", i, overflow, m_ovf); end
      checks++; if (peak_level !== m_peak[SW-2:0]) begin failures++; $display("FAIL rnd_peak i=%0d got=%h exp=%h", i, peak_level, m_peak[SW-2:0]); end
      if (m_q.size() != 0) begin
        checks++;
        if (sample_left !== m_q[0].l || sample_right !== m_q[0].r || sample_mono !== m_q[0].m) begin
          failures++; $display("FAIL rnd_head i=%0d got=%h/%h/%h exp=%h/%h/%h", i, sample_left, sample_right, sample_mono, m_q[0].l, m_q[0].r, m_q[0].m);
        end
      end
    end
    $display("test_random done level=%0d ovf=%0b peak=%h", fifo_level, overflow, peak_level);
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_mono_fwft();
    test_overflow();
    test_peak_decay();
    test_peak_hold_and_wrap_load();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
